// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers (MULTU/MULT/DIVU/DIV, MTHI/MTLO).
// Latency: 33 cycles from accepted start to HI/LO visible on o_dat, the same for every op.
// Backpressure: o_busy high while an op is in flight; i_start and HI/LO writes are ignored until IDLE.
module muldiv_unit (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_dat_a,
  input  logic [31:0] i_dat_b,
  input  logic        i_mthi,
  input  logic        i_mtlo,
  input  logic        i_sel_hi,
  output logic [31:0] o_dat,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;            // negate product / quotient at commit
  logic        neg_rem_q, neg_rem_d;    // negate remainder at commit (dividend sign)
  logic        div_zero_q, div_zero_d;
  logic [31:0] raw_a_q, raw_a_d;        // unmodified dividend, returned on divide by zero
  logic [31:0] opb_q, opb_d;            // multiplier (shifts right) or divisor (constant)
  logic [63:0] acc_q, acc_d;            // product accumulator, or {remainder, quotient/dividend}
  logic [63:0] mcand_q, mcand_d;        // multiplicand, shifts left one bit per step
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Operand magnitudes for the signed ops; 0x8000_0000 maps to itself, which is the
  // correct unsigned magnitude.
  logic        signed_op;
  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;

  assign signed_op = i_op[0];
  assign sign_a    = signed_op & i_dat_a[31];
  assign sign_b    = signed_op & i_dat_b[31];
  assign mag_a     = sign_a ? (32'd0 - i_dat_a) : i_dat_a;
  assign mag_b     = sign_b ? (32'd0 - i_dat_b) : i_dat_b;

  // Per-step datapath: one shift-add for multiply, one restoring trial subtract for divide.
  // The partial remainder never reaches the divisor, so the low 32 bits of the subtraction
  // are exact whenever the trial succeeds.
  logic [63:0] mul_sum;
  logic        div_ok;
  logic [31:0] div_sub;

  assign mul_sum = acc_q + (opb_q[0] ? mcand_q : 64'd0);
  assign div_ok  = (acc_q[63:31] >= {1'b0, opb_q});
  assign div_sub = acc_q[62:31] - opb_q;

  // Final sign correction applied on the commit edge.
  logic [63:0] prod_fin;
  logic [31:0] quo_fin;
  logic [31:0] rem_fin;

  assign prod_fin = neg_q     ? (64'd0 - acc_q)         : acc_q;
  assign quo_fin  = neg_q     ? (32'd0 - acc_q[31:0])   : acc_q[31:0];
  assign rem_fin  = neg_rem_q ? (32'd0 - acc_q[63:32])  : acc_q[63:32];

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, operand latch, iteration step and HI/LO commit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    raw_a_d    = raw_a_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          // Start takes priority over any MTHI/MTLO presented in the same cycle.
          state_d    = S_CALC;
          cnt_d      = 5'd0;
          is_div_d   = i_op[1];
          neg_d      = sign_a ^ sign_b;
          neg_rem_d  = sign_a;
          div_zero_d = i_op[1] & (i_dat_b == 32'd0);
          raw_a_d    = i_dat_a;
          opb_d      = mag_b;
          if (i_op[1]) begin
            acc_d   = {32'd0, mag_a};
            mcand_d = 64'd0;
          end else begin
            acc_d   = 64'd0;
            mcand_d = {32'd0, mag_a};
          end
        end else begin
          if (i_mthi) hi_d = i_dat_a;
          if (i_mtlo) lo_d = i_dat_a;
        end
      end

      S_CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (is_div_q) begin
          if (div_ok) begin
            acc_d = {div_sub, acc_q[30:0], 1'b1};
          end else begin
            acc_d = {acc_q[62:0], 1'b0};
          end
        end else begin
          acc_d   = mul_sum;
          mcand_d = {mcand_q[62:0], 1'b0};
          opb_d   = {1'b0, opb_q[31:1]};
        end
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        if (is_div_q) begin
          if (div_zero_q) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = raw_a_q;
          end else begin
            lo_d = quo_fin;
            hi_d = rem_fin;
          end
        end else begin
          hi_d = prod_fin[63:32];
          lo_d = prod_fin[31:0];
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and architectural HI/LO registers; reset clears everything so o_dat reads 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q      <= 5'd0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      raw_a_q    <= 32'd0;
      opb_q      <= 32'd0;
      acc_q      <= 64'd0;
      mcand_q    <= 64'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      raw_a_q    <= raw_a_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  // Status and read port are pure decodes of committed state, so reset clears them at once.
  assign o_busy = (state_q != S_IDLE);
  assign o_done = (state_q == S_DONE);
  assign o_dat  = i_sel_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expected HI/LO and done cycle,
// a monitor checks each done pulse, its width, and the committed HI/LO.
// Direct checks cover reset, MTHI/MTLO behaviour and mid-operation reset.
`timescale 1ns/1ps
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        sel_stim = 1'b0;
  logic        sel_mon = 1'b0;
  logic        mon_own = 1'b0;
  logic        sel_hi;
  logic [31:0] dat;
  logic        busy;
  logic        done;

  assign sel_hi = mon_own ? sel_mon : sel_stim;

  muldiv_unit dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_op     (op),
    .i_dat_a  (a),
    .i_dat_b  (b),
    .i_mthi   (mthi),
    .i_mtlo   (mtlo),
    .i_sel_hi (sel_hi),
    .o_dat    (dat),
    .o_busy   (busy),
    .o_done   (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one start request for a single cycle; optionally record the expected result.
  task automatic issue(input string name, input logic [1:0] o, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo,
                       input bit push, input bit whi, input bit wlo);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb; mthi = whi; mtlo = wlo;
    if (push) begin
      e.name = name; e.hi = ehi; e.lo = elo; e.cyc = cyc + 33;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
  endtask

  task automatic wait_idle;
    int k;
    k = 0;
    while (busy && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [31:0] va,
                     input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo);
    issue(name, o, va, vb, ehi, elo, 1'b1, 1'b0, 1'b0);
    wait_idle();
  endtask

  task automatic chk_hilo(input string name, input logic [31:0] ehi, input logic [31:0] elo);
    sel_stim = 1'b1; #1;
    chk({name, "_hi"}, dat, ehi);
    sel_stim = 1'b0; #1;
    chk({name, "_lo"}, dat, elo);
  endtask

  // Monitor: every done pulse must match the head of the scoreboard in timing and value.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done at cycle %0d, required no done", cyc);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_lat"}, cyc, e.cyc);
          mon_own = 1'b1;
          @(posedge clk); #1;
          chk({e.name, "_pulse"}, {31'd0, done}, 32'd0);
          sel_mon = 1'b1; #1;
          chk({e.name, "_hi"}, dat, e.hi);
          sel_mon = 1'b0; #1;
          chk({e.name, "_lo"}, dat, e.lo);
          mon_own = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #10;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk_hilo("rst", 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run("mult_m3x7", 2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("divu_7_2",  2'b10, 32'd7,         32'd2,         32'd1,         32'd3);
    run("div_m7_2",  2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_7_m2",  2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    run("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    run("divu_5_0",  2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
    run("div_m5_0",  2'b11, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // Start and MTLO presented mid-calculation must be ignored.
    issue("multu_3x4", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'hAA; b = 32'd1; mtlo = 1'b1;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    wait_idle();

    // MTHI in IDLE lands at the next edge; LO untouched.
    @(negedge clk);
    mthi = 1'b1; a = 32'h55;
    @(negedge clk);
    mthi = 1'b0;
    chk_hilo("mthi", 32'h55, 32'd12);

    // Start wins over MTHI/MTLO in the same cycle; o_dat holds old values while busy.
    issue("multu_1x1", 2'b00, 32'd1, 32'd1, 32'd0, 32'd1, 1'b1, 1'b1, 1'b1);
    chk_hilo("busy_hold", 32'h55, 32'd12);
    wait_idle();

    // MTHI and MTLO together write both registers.
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; a = 32'hDEAD_BEEF;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk_hilo("mt_both", 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Reset at iteration 10 aborts without touching HI/LO beyond clearing them.
    issue("abort", 2'b00, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk_hilo("abort", 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("multu_2x3", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
